// File: rtl/fifo_pkg.sv
// Shared constants and types for the single-clock FIFO buffer.
// Imported by the interface, the RTL, the assertion checker and the testbench.
package fifo_pkg;

    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int PTR_WIDTH = $clog2(DEPTH);

    typedef logic [WIDTH-1:0] data_t;
    // One extra MSB beyond the address bits separates "full" from "empty" after a wrap.
    typedef logic [PTR_WIDTH:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_buffer_if.sv
// Producer/consumer bundle for fifo_buffer.
// The master drives requests and write data; the slave (the FIFO) returns data and status.
interface fifo_buffer_if;
    import fifo_pkg::*;

    logic  wr_en;
    logic  rd_en;
    data_t wdata;
    data_t rdata;
    logic  full;
    logic  empty;
    logic  overflow;
    logic  underflow;

    modport master (
        output wr_en, rd_en, wdata,
        input  rdata, full, empty, overflow, underflow
    );

    modport slave (
        input  wr_en, rd_en, wdata,
        output rdata, full, empty, overflow, underflow
    );

endinterface : fifo_buffer_if

// File: rtl/fifo_buffer_sva.sv
// Concurrent properties for fifo_buffer: flag consistency, blocked-access stability,
// error-pulse causality and reset values.
module fifo_buffer_sva
    import fifo_pkg::*;
(
    input logic  wr_clk,
    input logic  rst,
    input logic  wr_en,
    input logic  rd_en,
    input logic  full,
    input logic  empty,
    input logic  overflow,
    input logic  underflow,
    input data_t rdata,
    input ptr_t  wr_ptr,
    input ptr_t  rd_ptr
);

    a_not_full_and_empty : assert property (
        @(posedge wr_clk) disable iff (rst) !(full && empty)
    );

    a_blocked_write_holds_ptr : assert property (
        @(posedge wr_clk) disable iff (rst) (wr_en && full) |=> $stable(wr_ptr)
    );

    a_blocked_read_holds_ptr : assert property (
        @(posedge wr_clk) disable iff (rst) (rd_en && empty) |=> ($stable(rd_ptr) && $stable(rdata))
    );

    a_overflow_cause : assert property (
        @(posedge wr_clk) disable iff (rst) overflow |-> $past(wr_en && full)
    );

    a_underflow_cause : assert property (
        @(posedge wr_clk) disable iff (rst) underflow |-> $past(rd_en && empty)
    );

    // Reset is asynchronous, so outputs must already be at their reset values at any edge seen under rst.
    a_reset_values : assert property (
        @(posedge wr_clk) rst |-> (empty && !full && !overflow && !underflow && (rdata == '0))
    );

endmodule : fifo_buffer_sva

// File: rtl/fifo_buffer.sv
// Single-clock FIFO: DEPTH x WIDTH storage, registered read data, full/empty flags
// and one-cycle overflow/underflow pulses for dropped accesses.
module fifo_buffer
    import fifo_pkg::*;
(
    input logic           wr_clk,
    input logic           rst,
    fifo_buffer_if.slave  bus
);

    data_t mem [DEPTH];
    ptr_t  wr_ptr;
    ptr_t  rd_ptr;
    data_t rdata_q;
    logic  overflow_q;
    logic  underflow_q;

    logic full;
    logic empty;
    logic do_wr;
    logic do_rd;

    // Flags come straight from the registered pointers, so they reflect pre-edge state.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_WIDTH] != rd_ptr[PTR_WIDTH]) &&
                   (wr_ptr[PTR_WIDTH-1:0] == rd_ptr[PTR_WIDTH-1:0]);

    assign do_wr = bus.wr_en && !full;
    assign do_rd = bus.rd_en && !empty;

    // NOTE: storage has no reset; contents are don't-care after reset, and leaving
    // the array unreset lets it map onto plain RAM instead of DEPTH*WIDTH flops.
    always_ff @(posedge wr_clk) begin
        if (do_wr) begin
            mem[wr_ptr[PTR_WIDTH-1:0]] <= bus.wdata;
        end
    end

    // NOTE: every sequential assignment is non-blocking so all registers update from
    // the same pre-edge values, regardless of statement order.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (do_wr) begin
            wr_ptr <= wr_ptr + ptr_t'(1);
        end
    end

    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            rd_ptr  <= '0;
            rdata_q <= '0;
        end else if (do_rd) begin
            rdata_q <= mem[rd_ptr[PTR_WIDTH-1:0]];
            rd_ptr  <= rd_ptr + ptr_t'(1);
        end
    end

    // Error pulses are recomputed every edge, so they never stick past one cycle.
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= bus.wr_en && full;
            underflow_q <= bus.rd_en && empty;
        end
    end

    assign bus.rdata     = rdata_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;

    fifo_buffer_sva u_sva (
        .wr_clk    (wr_clk),
        .rst       (rst),
        .wr_en     (bus.wr_en),
        .rd_en     (bus.rd_en),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow_q),
        .underflow (underflow_q),
        .rdata     (rdata_q),
        .wr_ptr    (wr_ptr),
        .rd_ptr    (rd_ptr)
    );

endmodule : fifo_buffer

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer: directed fill/drain/error/wrap/reset scenarios
// plus randomized traffic, all compared against a queue-based reference model.
module tb_fifo_buffer;
    import fifo_pkg::*;

    logic wr_clk;
    logic rst;

    fifo_buffer_if bus ();

    fifo_buffer dut (
        .wr_clk (wr_clk),
        .rst    (rst),
        .bus    (bus.slave)
    );

    initial wr_clk = 1'b0;
    always #5 wr_clk = ~wr_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: contents as a queue, plus expected registered outputs.
    data_t model_q[$];
    data_t exp_rdata;
    logic  exp_ovf;
    logic  exp_udf;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".rdata"},     32'(bus.rdata),     32'(exp_rdata));
        check({tag, ".full"},      32'(bus.full),      32'(model_q.size() == DEPTH));
        check({tag, ".empty"},     32'(bus.empty),     32'(model_q.size() == 0));
        check({tag, ".overflow"},  32'(bus.overflow),  32'(exp_ovf));
        check({tag, ".underflow"}, 32'(bus.underflow), 32'(exp_udf));
    endtask

    // One clock of traffic: inputs change on the falling edge, outputs are checked 1 time unit after the rising edge.
    task automatic step(input string tag, input logic wr, input logic rd, input data_t d);
        bit pre_full;
        bit pre_empty;
        @(negedge wr_clk);
        bus.wr_en = wr;
        bus.rd_en = rd;
        bus.wdata = d;
        pre_full  = (model_q.size() == DEPTH);
        pre_empty = (model_q.size() == 0);
        @(posedge wr_clk);
        #1;
        exp_ovf = wr && pre_full;
        exp_udf = rd && pre_empty;
        if (rd && !pre_empty) exp_rdata = model_q.pop_front();
        if (wr && !pre_full)  model_q.push_back(d);
        check_outputs(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rdata = '0;
        exp_ovf   = 1'b0;
        exp_udf   = 1'b0;
    endtask

    initial begin
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        bus.wdata = '0;
        rst       = 1'b0;
        model_reset();

        // Reset held for two rising edges.
        #2 rst = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        check_outputs("reset");
        @(negedge wr_clk);
        rst = 1'b0;

        // Fill with 0x01..0x10, then one write while full.
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, data_t'(i + 1));
        check("fill.full_after_16", 32'(bus.full), 32'd1);
        step("overflow", 1'b1, 1'b0, 8'hAA);
        check("overflow.pulse", 32'(bus.overflow), 32'd1);
        step("overflow_clear", 1'b0, 1'b0, '0);

        // Drain: data must come back 0x01..0x10, never 0xAA.
        for (int i = 0; i < DEPTH; i++) begin
            step("drain", 1'b0, 1'b1, '0);
            check("drain.order", 32'(bus.rdata), 32'(i + 1));
        end

        // Read while empty: pulse, rdata keeps 0x10.
        step("underflow", 1'b0, 1'b1, '0);
        check("underflow.pulse", 32'(bus.underflow), 32'd1);
        check("underflow.rdata_held", 32'(bus.rdata), 32'h10);
        step("underflow_clear", 1'b0, 1'b0, '0);

        // Wrap: write 10, read 10, write 12 so both pointers cross DEPTH.
        for (int i = 0; i < 10; i++) step("wrap.wr10", 1'b1, 1'b0, data_t'(8'h20 + i));
        for (int i = 0; i < 10; i++) step("wrap.rd10", 1'b0, 1'b1, '0);
        for (int i = 0; i < 12; i++) step("wrap.wr12", 1'b1, 1'b0, data_t'(8'h40 + i));
        for (int i = 0; i < 7; i++)  step("wrap.rd7",  1'b0, 1'b1, '0);

        // Simultaneous read/write at occupancy 5 keeps occupancy at 5.
        for (int i = 0; i < 8; i++) step("concurrent", 1'b1, 1'b1, data_t'(8'h60 + i));
        check("concurrent.occupancy", 32'(model_q.size()), 32'd5);
        for (int i = 0; i < 5; i++) step("concurrent.drain", 1'b0, 1'b1, '0);

        // Simultaneous access at the boundaries: empty (write wins) and full (read wins).
        step("both_at_empty", 1'b1, 1'b1, 8'h77);
        for (int i = 0; i < DEPTH - 1; i++) step("refill", 1'b1, 1'b0, data_t'(8'h80 + i));
        step("both_at_full", 1'b1, 1'b1, 8'hBB);
        for (int i = 0; i < DEPTH; i++) step("boundary.drain", 1'b0, 1'b1, '0);

        // Randomized traffic: a write-heavy phase then a read-heavy phase.
        for (int i = 0; i < 600; i++) begin
            int pw;
            pw = (i < 300) ? 70 : 30;
            step("random", ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < (100 - pw)),
                 data_t'($urandom));
        end

        // Reset mid-operation with 7 entries stored.
        while (model_q.size() > 0) step("pre_reset.drain", 1'b0, 1'b1, '0);
        for (int i = 0; i < 7; i++) step("pre_reset.fill", 1'b1, 1'b0, data_t'(8'hC0 + i));
        @(negedge wr_clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("mid_reset.async");
        @(posedge wr_clk);
        #1;
        check_outputs("mid_reset.held");
        @(negedge wr_clk);
        rst = 1'b0;
        step("post_reset.read", 1'b0, 1'b1, '0);
        check("post_reset.underflow", 32'(bus.underflow), 32'd1);
        step("post_reset.idle", 1'b0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_fifo_buffer
